// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - three-stage sprite pixel renderer with internal bitmap ROMs
module sprite_renderer #(
  parameter int BLINK_BIT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [2:0] element_type,
  input  logic [9:0] element_x,
  input  logic [9:0] element_y,
  input  logic [1:0] frame,
  input  logic [1:0] sprite_color,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync_out,
  output logic       vsync_out
);

  // Ship art, one 16-bit word per row, bit index = column (shown 2x upscaled)
  function automatic logic [15:0] ship_row(input logic [3:0] r);
    case (r)
      4'd0, 4'd1:   ship_row = 16'h0180;
      4'd2, 4'd3:   ship_row = 16'h03C0;
      4'd4, 4'd5:   ship_row = 16'h07E0;
      4'd6, 4'd7:   ship_row = 16'h0FF0;
      4'd8:         ship_row = 16'h1FF8;
      4'd9, 4'd10:  ship_row = 16'h3FFC;
      4'd11, 4'd12: ship_row = 16'h7FFE;
      default:      ship_row = 16'hFFFF;
    endcase
  endfunction

  // Alien pose A: legs out on the bottom row
  function automatic logic [15:0] alien_a_row(input logic [3:0] r);
    case (r)
      4'd0:         alien_a_row = 16'h0180;
      4'd1:         alien_a_row = 16'h03C0;
      4'd2:         alien_a_row = 16'h07E0;
      4'd3:         alien_a_row = 16'h0DB0;
      4'd4, 4'd5:   alien_a_row = 16'h1FF8;
      4'd6:         alien_a_row = 16'h0A50;
      4'd7:         alien_a_row = 16'h1008;
      4'd15:        alien_a_row = 16'h8001;
      default:      alien_a_row = 16'h0810;
    endcase
  endfunction

  // Alien pose B: legs tucked in on the bottom row
  function automatic logic [15:0] alien_b_row(input logic [3:0] r);
    case (r)
      4'd0:         alien_b_row = 16'h0180;
      4'd1:         alien_b_row = 16'h03C0;
      4'd2:         alien_b_row = 16'h07E0;
      4'd3:         alien_b_row = 16'h0DB0;
      4'd4, 4'd5:   alien_b_row = 16'h1FF8;
      4'd6:         alien_b_row = 16'h05A0;
      4'd15:        alien_b_row = 16'h0660;
      default:      alien_b_row = 16'h0240;
    endcase
  endfunction

  // Explosion burst: dark corner, lit centre
  function automatic logic [15:0] expl_row(input logic [3:0] r);
    case (r)
      4'd0:         expl_row = 16'h0000;
      4'd4, 4'd12:  expl_row = 16'h2244;
      4'd8:         expl_row = 16'h4924;
      default:      expl_row = 16'h1008;
    endcase
  endfunction

  // Rocket: 8 columns wide, centre columns always lit, edge columns always dark
  function automatic logic [7:0] rocket_row(input logic [3:0] r);
    case (r)
      4'd0, 4'd1:   rocket_row = 8'h18;
      4'd14, 4'd15: rocket_row = 8'h7E;
      default:      rocket_row = 8'h3C;
    endcase
  endfunction

  logic [9:0] s1_dx, s1_dy;
  logic [2:0] s1_type;
  logic [1:0] s1_color;
  logic       s1_video, s1_hs, s1_vs;

  logic       s2_hit, s2_video, s2_hs, s2_vs;
  logic [1:0] s2_color;

  logic       vsync_q;
  logic [1:0] frame_l;
  logic [7:0] blink_cnt;

  logic        in_bounds, rom_bit, hit;
  logic [15:0] row16;
  logic [7:0]  row8;

  // Only the low frame bit selects an alien pose
  logic unused_frame_bit;
  assign unused_frame_bit = frame_l[1];

  // Stage 1: element-relative offsets plus sideband capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_type  <= '0;
      s1_color <= '0;
      s1_video <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
    end else begin
      s1_dx    <= x - element_x;
      s1_dy    <= y - element_y;
      s1_type  <= element_type;
      s1_color <= sprite_color;
      s1_video <= video_on;
      s1_hs    <= hsync_in;
      s1_vs    <= vsync_in;
    end
  end

  // Bounds check and bitmap lookup for the stage-1 pixel
  always_comb begin
    in_bounds = 1'b0;
    rom_bit   = 1'b0;
    row16     = '0;
    row8      = '0;
    case (s1_type)
      3'b000: begin
        in_bounds = (s1_dx < 10'd32) && (s1_dy < 10'd32);
        row16     = ship_row(s1_dy[4:1]);
        rom_bit   = row16[s1_dx[4:1]];
      end
      3'b001: begin
        in_bounds = (s1_dx < 10'd16) && (s1_dy < 10'd16);
        row16     = frame_l[0] ? alien_b_row(s1_dy[3:0]) : alien_a_row(s1_dy[3:0]);
        rom_bit   = row16[s1_dx[3:0]];
      end
      3'b100: begin
        in_bounds = (s1_dx < 10'd16) && (s1_dy < 10'd16);
        row16     = expl_row(s1_dy[3:0]);
        rom_bit   = row16[s1_dx[3:0]] && (s1_color == 2'b11) && !blink_cnt[BLINK_BIT];
      end
      3'b101: begin
        in_bounds = (s1_dx < 10'd8) && (s1_dy < 10'd16);
        row8      = rocket_row(s1_dy[3:0]);
        rom_bit   = row8[s1_dx[2:0]];
      end
      default: begin
        in_bounds = 1'b0;
        rom_bit   = 1'b0;
      end
    endcase
    hit = in_bounds && rom_bit;
  end

  // Stage 2: registered hit decision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_hit   <= 1'b0;
      s2_color <= '0;
      s2_video <= 1'b0;
      s2_hs    <= 1'b1;
      s2_vs    <= 1'b1;
    end else begin
      s2_hit   <= hit;
      s2_color <= s1_color;
      s2_video <= s1_video;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
    end
  end

  // Stage 3: colour map and sync outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      hsync_out <= s2_hs;
      vsync_out <= s2_vs;
      if (s2_video && s2_hit) begin
        case (s2_color)
          2'b00:   {vga_r, vga_g, vga_b} <= 12'hFFF;
          2'b01:   {vga_r, vga_g, vga_b} <= 12'h0F0;
          2'b10:   {vga_r, vga_g, vga_b} <= 12'hF00;
          default: {vga_r, vga_g, vga_b} <= 12'hFA0;
        endcase
      end else begin
        {vga_r, vga_g, vga_b} <= 12'h000;
      end
    end
  end

  // Per-field state: latch animation frame and advance blink counter on vsync fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q   <= 1'b1;
      frame_l   <= '0;
      blink_cnt <= '0;
    end else begin
      vsync_q <= vsync_in;
      if (vsync_q && !vsync_in) begin
        frame_l   <= frame;
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// tb/tb_sprite_renderer.sv - randomized and directed bench for sprite_renderer
module tb_sprite_renderer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic       video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [2:0] element_type = '0;
  logic [9:0] element_x = '0, element_y = '0;
  logic [1:0] frame = '0, sprite_color = '0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hsync_out, vsync_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #10 clk = ~clk;

  sprite_renderer dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .element_type(element_type),
    .element_x(element_x), .element_y(element_y), .frame(frame),
    .sprite_color(sprite_color), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // rgb is the expected colour; alt is a second acceptable value for free-art pixels
  typedef struct {
    logic [11:0] rgb;
    logic [11:0] alt;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t pipe [3];
  int   m_frame_l, m_blink;
  bit   m_vsync_q;

  function automatic exp_t predict(input logic [2:0] t, input logic [1:0] c,
                                   input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] ex, input logic [9:0] ey,
                                   input logic v, input logic hs, input logic vs,
                                   input int fl, input int bl);
    exp_t e;
    logic [9:0] dx10, dy10;
    int dx, dy, st;
    logic [11:0] col;
    dx10 = px - ex;
    dy10 = py - ey;
    dx = int'(dx10);
    dy = int'(dy10);
    st = 0; // 0 dark, 1 lit, 2 free art
    case (c)
      2'd0: col = 12'hFFF;
      2'd1: col = 12'h0F0;
      2'd2: col = 12'hF00;
      default: col = 12'hFA0;
    endcase
    if (v) begin
      case (t)
        3'b000: if (dx < 32 && dy < 32) begin
          if (dy / 2 == 0) st = (dx / 2 == 7 || dx / 2 == 8) ? 1 : 0;
          else if (dy / 2 == 15) st = 1;
          else st = 2;
        end
        3'b001: if (dx < 16 && dy < 16) begin
          if (dy == 15 && (dx == 0 || dx == 15)) st = (fl % 2 == 0) ? 1 : 0;
          else st = 2;
        end
        3'b100: if (c == 2'b11 && ((bl / 4) % 2 == 0) && dx < 16 && dy < 16) begin
          if (dx == 8 && dy == 8) st = 1;
          else if (dx == 0 && dy == 0) st = 0;
          else st = 2;
        end
        3'b101: if (dx < 8 && dy < 16) begin
          if (dx == 3 || dx == 4) st = 1;
          else if (dx == 0 || dx == 7) st = 0;
          else st = 2;
        end
        default: st = 0;
      endcase
    end
    e.rgb = (st != 0) ? col : 12'h000;
    e.alt = (st == 2) ? 12'h000 : e.rgb;
    e.hs  = hs;
    e.vs  = vs;
    return e;
  endfunction

  // Reference model: field state plus a three-deep expectation pipe
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{12'h000, 12'h000, 1'b1, 1'b1};
      m_frame_l = 0;
      m_blink   = 0;
      m_vsync_q = 1'b1;
    end else begin
      if (m_vsync_q && !vsync_in) begin
        m_frame_l = int'(frame);
        m_blink   = (m_blink + 1) % 256;
      end
      m_vsync_q = vsync_in;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = predict(element_type, sprite_color, x, y, element_x, element_y,
                        video_on, hsync_in, vsync_in, m_frame_l, m_blink);
    end
  end

  // Compare DUT outputs against the model every cycle, away from the clock edge
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if ({vga_r, vga_g, vga_b} !== pipe[2].rgb && {vga_r, vga_g, vga_b} !== pipe[2].alt) begin
        errors++;
        $display("FAIL model_rgb t=%0t got=%h expected=%h or %h", $time,
                 {vga_r, vga_g, vga_b}, pipe[2].rgb, pipe[2].alt);
      end
      checks++;
      if (hsync_out !== pipe[2].hs || vsync_out !== pipe[2].vs) begin
        errors++;
        $display("FAIL model_sync t=%0t got hs=%b vs=%b expected hs=%b vs=%b", $time,
                 hsync_out, vsync_out, pipe[2].hs, pipe[2].vs);
      end
    end
  end

  task automatic lit(input string name, input logic [11:0] exp);
    checks++;
    if ({vga_r, vga_g, vga_b} !== exp) begin
      errors++;
      $display("FAIL %s rgb got=%h expected=%h", name, {vga_r, vga_g, vga_b}, exp);
    end
  endtask

  task automatic lit_hs(input string name, input logic exp);
    checks++;
    if (hsync_out !== exp) begin
      errors++;
      $display("FAIL %s hsync_out got=%b expected=%b", name, hsync_out, exp);
    end
  endtask

  task automatic set_px(input logic [2:0] t, input logic [1:0] c,
                        input logic [9:0] ex, input logic [9:0] ey,
                        input logic [9:0] px, input logic [9:0] py);
    element_type = t; sprite_color = c;
    element_x = ex; element_y = ey; x = px; y = py;
  endtask

  task automatic wait3();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic vs_pulse();
    vsync_in = 1'b0;
    @(negedge clk);
    vsync_in = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    reset_n = 1'b1;
    video_on = 1'b1;

    // Mid-stream reset: immediate outputs, then first valid pixel on 3rd clock
    set_px(3'b000, 2'b00, 10'd304, 10'd428, 10'd318, 10'd428);
    repeat (4) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    lit("reset_rgb", 12'h000);
    checks++;
    if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_sync got hs=%b vs=%b expected 1 1", hsync_out, vsync_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    lit("reset_2nd_clock", 12'h000);
    @(negedge clk);
    lit("ship_row0_col7", 12'hFFF);

    // Ship lookups
    set_px(3'b000, 2'b00, 10'd304, 10'd428, 10'd304, 10'd428);
    wait3();
    lit("ship_row0_col0", 12'h000);
    set_px(3'b000, 2'b00, 10'd304, 10'd428, 10'd304, 10'd458);
    wait3();
    lit("ship_row15", 12'hFFF);

    // Alien animation: frame input changes take effect only on vsync fall
    frame = 2'd1;
    set_px(3'b001, 2'b01, 10'd80, 10'd40, 10'd80, 10'd55);
    wait3();
    lit("alien_frame_a", 12'h0F0);
    vs_pulse();
    wait3();
    lit("alien_frame_b", 12'h000);

    // Explosion blink cycle
    do_reset();
    set_px(3'b100, 2'b11, 10'd200, 10'd100, 10'd208, 10'd108);
    wait3();
    lit("expl_visible", 12'hFA0);
    repeat (4) vs_pulse();
    wait3();
    lit("expl_blank_4", 12'h000);
    repeat (4) vs_pulse();
    wait3();
    lit("expl_visible_8", 12'hFA0);

    // Background, reserved, blanking
    set_px(3'b100, 2'b00, 10'd200, 10'd100, 10'd208, 10'd108);
    wait3();
    lit("background", 12'h000);
    set_px(3'b111, 2'b00, 10'd200, 10'd100, 10'd208, 10'd108);
    wait3();
    lit("reserved", 12'h000);
    set_px(3'b101, 2'b00, 10'd300, 10'd200, 10'd303, 10'd210);
    video_on = 1'b0;
    wait3();
    lit("rocket_blanked", 12'h000);
    video_on = 1'b1;
    wait3();
    lit("rocket_visible", 12'hFFF);

    // One-clock hsync pulse appears exactly 3 clocks later
    hsync_in = 1'b0;
    @(negedge clk);
    hsync_in = 1'b1;
    lit_hs("hs_d1", 1'b1);
    @(negedge clk);
    lit_hs("hs_d2", 1'b1);
    @(negedge clk);
    lit_hs("hs_d3", 1'b0);
    @(negedge clk);
    lit_hs("hs_d4", 1'b1);

    // Randomized traffic near element origins
    for (int n = 0; n < 3000; n++) begin
      int off_x, off_y, tsel;
      tsel = $urandom_range(0, 9);
      case (tsel)
        0, 1, 2: element_type = 3'b000;
        3, 4:    element_type = 3'b001;
        5, 6:    element_type = 3'b100;
        7, 8:    element_type = 3'b101;
        default: element_type = 3'($urandom);
      endcase
      sprite_color = 2'($urandom);
      element_x = 10'($urandom);
      element_y = 10'($urandom);
      off_x = $urandom_range(0, 38) - 3;
      off_y = $urandom_range(0, 38) - 3;
      x = element_x + 10'(off_x);
      y = element_y + 10'(off_y);
      video_on = ($urandom_range(0, 9) != 0);
      hsync_in = ($urandom_range(0, 7) != 0);
      vsync_in = ($urandom_range(0, 5) != 0);
      frame = 2'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #3 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    hsync_in = 1'b1;
    vsync_in = 1'b1;
    wait3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
